// File: rtl/change_ctrl_if.sv
// rtl/change_ctrl_if.sv - coin ejector four-phase req/ack handshake
interface change_ctrl_if;
    logic       eject_req;
    logic [1:0] eject_sel;
    logic       eject_ack;

    modport master (output eject_req, output eject_sel, input eject_ack);
    modport slave  (input eject_req, input eject_sel, output eject_ack);
endinterface

// File: rtl/change_ctrl.sv
// rtl/change_ctrl.sv - coin-return controller, largest coin first over req/ack
module change_ctrl #(
    parameter int PRICE   = 75,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_total,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_fault,
    output logic [W-1:0] o_change_out,
    output logic [4:0]   o_coin_cnt,
    change_ctrl_if.master ej
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_REQ, S_WAIT_REL, S_DONE, S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_remaining;
    logic [1:0]    r_sel;
    logic [4:0]    r_coin_cnt;
    logic [CW-1:0] r_tcnt;
    logic          r_armed;
    logic [1:0]    w_coin_sel;
    logic [W-1:0]  w_coin_val;
    logic          w_take_start;

    // start is captured in IDLE and acted on the following cycle
    assign w_take_start = (r_state == S_IDLE) && i_start && !r_armed;

    always_comb begin
        w_coin_sel = 2'b00;
        if (r_remaining >= W'(25))
            w_coin_sel = 2'b11;
        else if (r_remaining >= W'(10))
            w_coin_sel = 2'b10;
        else if (r_remaining >= W'(5))
            w_coin_sel = 2'b01;
    end

    always_comb begin
        w_coin_val = '0;
        case (r_sel)
            2'b01:   w_coin_val = W'(5);
            2'b10:   w_coin_val = W'(10);
            2'b11:   w_coin_val = W'(25);
            default: w_coin_val = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (r_armed) w_next = S_CALC;
            S_CALC:     w_next = (w_coin_sel != 2'b00) ? S_REQ : S_DONE;
            S_REQ: begin
                if (ej.eject_ack)
                    w_next = S_WAIT_REL;
                else if (r_tcnt == CW'(TIMEOUT))
                    w_next = S_FAULT;
            end
            S_WAIT_REL: if (!ej.eject_ack) w_next = S_CALC;
            S_DONE:     w_next = S_IDLE;
            S_FAULT:    w_next = S_FAULT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_sel       <= 2'b00;
            r_coin_cnt  <= '0;
            r_tcnt      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= w_take_start;
            if (w_take_start) begin
                r_remaining <= (i_total >= W'(PRICE)) ? (i_total - W'(PRICE)) : i_total;
                r_coin_cnt  <= '0;
            end
            if (r_state == S_CALC) begin
                r_sel  <= w_coin_sel;
                r_tcnt <= '0;
            end
            if (r_state == S_REQ) begin
                if (ej.eject_ack) begin
                    r_remaining <= r_remaining - w_coin_val;
                    if (r_coin_cnt != 5'd31)
                        r_coin_cnt <= r_coin_cnt + 5'd1;
                end else if (r_tcnt != CW'(TIMEOUT)) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_fault      = (r_state == S_FAULT);
    assign o_change_out = r_remaining;
    assign o_coin_cnt   = r_coin_cnt;
    assign ej.eject_req = (r_state == S_REQ);
    assign ej.eject_sel = r_sel;
endmodule

// File: doc/change_ctrl.md
# change_ctrl

Coin-return controller for the soda machine. After the main FSM enters dispense, or when the total is refunded, this block computes the change owed from the latched total and the soda price. It then sequences a coin ejector, largest coin first, over a four-phase req/ack handshake. It reports completion, any sub-nickel residue, and ejector faults.

## Interface
- PRICE, 75: soda price in cents.
- W, 8: width of total/change values in cents.
- TIMEOUT, 255: max cycles to wait for eject_ack in REQ before faulting.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; samples total; ignored unless state is IDLE.
- total  in  W  amount deposited, in cents; valid only with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a change sequence completes.
- fault  out  1  high in FAULT; stays high until rst.
- eject_req  out  1  request the ejector to release one coin of type eject_sel.
- eject_sel  out  2  coin type: 00 none, 01 nickel (5), 10 dime (10), 11 quarter (25).
- eject_ack  in  1  ejector acknowledge for the four-phase handshake.
- change_out  out  W  change still owed; after done, holds the undispensable residue (0–4).
- coin_cnt  out  5  coins ejected in the current sequence; saturates at 31.

## Operation
- States: IDLE, CALC, REQ, WAIT_REL, DONE, FAULT. State is registered, and all outputs are registered or decoded from the state register.
- IDLE: busy=0, eject_req=0. On start:
  - load remaining = total−PRICE if total ≥ PRICE, else total (full refund);
  - clear coin_cnt;
  - go to CALC.
- CALC: select a coin from remaining.
  - ≥25 → quarter; ≥10 → dime; ≥5 → nickel.
  - With a coin selected: register eject_sel and go to REQ.
  - If remaining < 5 (including 0): go to DONE, eject_sel=00.
- REQ: eject_req=1 and eject_sel stable. Clear the timeout counter on entry.
  - When eject_ack=1: subtract the coin value from remaining, increment coin_cnt (saturating), go to WAIT_REL.
  - If the counter reaches TIMEOUT without ack: go to FAULT.
- WAIT_REL: eject_req=0, eject_sel held. When eject_ack=0, go to CALC. There is no timeout in this state.
- DONE: done=1 for exactly one cycle, then IDLE. change_out keeps the residue until the next start.
- FAULT: fault=1, busy=1, eject_req=0. Only rst exits.
- Arithmetic:
  - the subtraction is W-bit unsigned and cannot underflow, because a coin is selected only when remaining ≥ its value;
  - the timeout counter is $clog2(TIMEOUT+1) bits.
- start while busy is ignored, with no effect on the sequence in progress.
- An eject_ack already high when REQ is entered is accepted on the first REQ cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, fault=0, eject_req=0, eject_sel=00, change_out=0, coin_cnt=0, timeout counter=0.
- rst mid-sequence takes priority over every other input:
  - the next state is IDLE and all outputs return to reset values the following cycle;
  - eject_req drops without waiting for ack;
  - the owed change is discarded.
- Latency, with start sampled on edge 0:
  - CALC on edge 1;
  - eject_req high after edge 2;
  - with zero change, done is high after edge 2 and busy is low after edge 3.
- Per coin with an ack that rises and falls immediately:
  - REQ 1 cycle, WAIT_REL 1 cycle, CALC 1 cycle, so 3 cycles per coin;
  - eject_req is low for at least 2 cycles between coins.
- Fault timing: with no ack, fault rises TIMEOUT+1 cycles after REQ is entered.

## Test plan
- total=100, ack pulses 1 cycle later → one quarter (11), coin_cnt=1, change_out=0, one done pulse.
- total=90 → dime then nickel, in that order; eject_req low between them; coin_cnt=2, change_out=0.
- total=50 (below PRICE) → refund of two quarters; total=75 → no eject_req, done 2 cycles after start.
- total=77 → done with eject_req never asserted, change_out=2, coin_cnt=0. Also: start pulsed during an active sequence → ignored, the sequence is unchanged.
- eject_ack held low in REQ → fault=1 TIMEOUT+1 cycles after REQ entry, eject_req=0, state held until rst.
- rst asserted while eject_req=1 and ack pending → all outputs at reset values next cycle; a new start with total=100 then completes normally.
